// File: rtl/pet_display_sequencer.sv
// Pages the pet status word and six stats onto one 7-segment digit.
// Advances on a synchronized button edge or a dwell timer; low stats blink.
module pet_display_sequencer #(
  parameter logic [23:0] DWELL_COUNT = 24'd10_000_000,
  parameter logic [23:0] BLINK_COUNT = 24'd2_500_000,
  parameter logic [3:0]  LOW_THRESH  = 4'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] hunger,
  input  logic [3:0] happiness,
  input  logic [3:0] health,
  input  logic [3:0] hygiene,
  input  logic [3:0] energy,
  input  logic [3:0] social,
  input  logic [6:0] status,
  input  logic       btn_next,
  input  logic       auto_mode,
  output logic [6:0] seg_out,
  output logic       dp,
  output logic [2:0] page
);

  typedef enum logic [2:0] {
    PG_STATUS    = 3'd0,
    PG_HUNGER    = 3'd1,
    PG_HAPPINESS = 3'd2,
    PG_HEALTH    = 3'd3,
    PG_HYGIENE   = 3'd4,
    PG_ENERGY    = 3'd5,
    PG_SOCIAL    = 3'd6
  } page_e;

  logic        sync1_q, sync2_q;
  logic        btn_prev_q, btn_prev_d;
  page_e       page_q, page_d;
  logic [23:0] dwell_q, dwell_d;
  logic [23:0] blink_q, blink_d;
  logic        phase_q, phase_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic        btn_edge, dwell_done, advance, blink_on;
  logic [3:0]  shown;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Synchronizer keeps sampling even while frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_next;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev_q <= 1'b0;
      page_q     <= PG_STATUS;
      dwell_q    <= '0;
      blink_q    <= '0;
      phase_q    <= 1'b1;
      seg_q      <= '0;
      dp_q       <= 1'b0;
    end else begin
      btn_prev_q <= btn_prev_d;
      page_q     <= page_d;
      dwell_q    <= dwell_d;
      blink_q    <= blink_d;
      phase_q    <= phase_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  always_comb begin
    case (page_q)
      PG_HUNGER:    shown = hunger;
      PG_HAPPINESS: shown = happiness;
      PG_HEALTH:    shown = health;
      PG_HYGIENE:   shown = hygiene;
      PG_ENERGY:    shown = energy;
      PG_SOCIAL:    shown = social;
      default:      shown = '0;
    endcase
    btn_edge   = sync2_q & ~btn_prev_q;
    dwell_done = auto_mode && (dwell_q == DWELL_COUNT - 24'd1);
    advance    = ena && (btn_edge || dwell_done);
    blink_on   = (page_q != PG_STATUS) && (shown <= LOW_THRESH);

    btn_prev_d = btn_prev_q;
    page_d     = page_q;
    dwell_d    = dwell_q;
    blink_d    = blink_q;
    phase_d    = phase_q;
    seg_d      = seg_q;
    dp_d       = dp_q;

    if (ena) begin
      btn_prev_d = sync2_q;
      // Manual and auto advances merge into one step.
      if (advance)
        page_d = (page_q == PG_SOCIAL) ? PG_STATUS : page_e'(page_q + 3'd1);
      dwell_d = (advance || !auto_mode) ? '0 : dwell_q + 24'd1;
      if (advance) begin
        blink_d = '0;
        phase_d = 1'b1;
      end else if (blink_q == BLINK_COUNT - 24'd1) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 24'd1;
      end
      dp_d = (page_q != PG_STATUS);
      if (page_q == PG_STATUS)
        seg_d = status;
      else if (blink_on && !phase_q)
        seg_d = '0;
      else
        seg_d = hex7(shown);
    end
  end

  assign seg_out = seg_q;
  assign dp      = dp_q;
  assign page    = page_q;

endmodule

// File: tb/tb_pet_display_sequencer.sv
// Randomized and directed bench for pet_display_sequencer against a
// cycle-level behavioural model of the paging, dwell and blink rules.
module tb_pet_display_sequencer;
  localparam int D = 8;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       btn = 1'b0;
  logic       auto_m = 1'b0;
  logic [3:0] stv [1:6];
  logic [6:0] status = 7'h00;
  logic [6:0] seg;
  logic       dp_o;
  logic [2:0] pg;

  int n_cmp = 0;
  int n_err = 0;

  int HEX [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                   'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

  int m_s1, m_s2, m_prev, m_page, m_dc, m_bc, m_ph, m_seg, m_dp;

  pet_display_sequencer #(
    .DWELL_COUNT(24'd8),
    .BLINK_COUNT(24'd2),
    .LOW_THRESH (4'd3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .hunger   (stv[1]),
    .happiness(stv[2]),
    .health   (stv[3]),
    .hygiene  (stv[4]),
    .energy   (stv[5]),
    .social   (stv[6]),
    .status   (status),
    .btn_next (btn),
    .auto_mode(auto_m),
    .seg_out  (seg),
    .dp       (dp_o),
    .page     (pg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_prev = 0; m_page = 0;
    m_dc = 0; m_bc = 0; m_ph = 1; m_seg = 0; m_dp = 0;
  endtask

  // One rising edge worth of behaviour, using the inputs currently applied.
  task automatic model_step();
    int adv;
    int stat;
    if (ena) begin
      adv  = ((m_s2 == 1 && m_prev == 0) || (auto_m && m_dc == D - 1)) ? 1 : 0;
      stat = (m_page == 0) ? 0 : int'(stv[m_page]);
      m_dp = (m_page != 0) ? 1 : 0;
      if (m_page == 0)                 m_seg = int'(status);
      else if (stat <= 3 && m_ph == 0) m_seg = 0;
      else                             m_seg = HEX[stat];
      m_prev = m_s2;
      m_dc   = (adv == 1 || !auto_m) ? 0 : m_dc + 1;
      if (adv == 1) begin
        m_bc = 0; m_ph = 1;
      end else if (m_bc == B - 1) begin
        m_bc = 0; m_ph = 1 - m_ph;
      end else begin
        m_bc++;
      end
      if (adv == 1) m_page = (m_page + 1) % 7;
    end
    m_s2 = m_s1;
    m_s1 = int'(btn);
  endtask

  // Called right after a falling edge; inputs are already applied.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("page", int'(pg), m_page);
    check("seg", int'(seg), m_seg);
    check("dp", int'(dp_o), m_dp);
  endtask

  // Asserts reset between clock edges and releases it before the next rising edge.
  task automatic reset_mid();
    #2 rst_n = 1'b0;
    #1;
    check("rst_page", int'(pg), 0);
    check("rst_seg", int'(seg), 0);
    check("rst_dp", int'(dp_o), 0);
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  task automatic press();
    btn = 1'b1;
    step();
    btn = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    int n_vis;
    int n_blank;
    int idx;
    stv[1] = 4'h9; stv[2] = 4'hA; stv[3] = 4'h5;
    stv[4] = 4'h7; stv[5] = 4'hC; stv[6] = 4'hE;
    status = 7'h55;
    model_reset();
    @(negedge clk);
    reset_mid();

    // Manual paging
    repeat (3) step();
    check("pre_seg", int'(seg), 'h55);
    check("pre_dp", int'(dp_o), 0);
    press();
    check("m1_page", int'(pg), 1);
    check("m1_seg", int'(seg), 'h6F);
    check("m1_dp", int'(dp_o), 1);
    press();
    check("m2_seg", int'(seg), 'h77);
    btn = 1'b1;
    repeat (20) step();
    btn = 1'b0;
    repeat (4) step();
    check("hold_page", int'(pg), 3);

    // Auto wrap and manual press mid-dwell
    reset_mid();
    auto_m = 1'b1;
    repeat (8) step();
    check("auto_p1", int'(pg), 1);
    repeat (48) step();
    check("auto_wrap", int'(pg), 0);
    repeat (3) step();
    btn = 1'b1;
    step();
    btn = 1'b0;
    repeat (2) step();
    check("mid_press", int'(pg), 1);
    repeat (7) step();
    check("dwell_restart_hold", int'(pg), 1);
    step();
    check("dwell_restart_adv", int'(pg), 2);

    // Simultaneous manual and auto advance
    reset_mid();
    repeat (5) step();
    btn = 1'b1;
    step();
    btn = 1'b0;
    repeat (2) step();
    check("simul", int'(pg), 1);
    repeat (3) step();

    // Blink on a low stat
    reset_mid();
    auto_m = 1'b0;
    stv[3] = 4'h2;
    repeat (3) press();
    check("blink_page", int'(pg), 3);
    n_vis = 0;
    n_blank = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (seg == 7'h5B) n_vis++;
      if (seg == 7'h00) n_blank++;
    end
    check("blink_vis", n_vis, 4);
    check("blink_blank", n_blank, 4);
    stv[3] = 4'h4;
    repeat (2) step();
    for (int i = 0; i < 6; i++) begin
      step();
      check("steady66", int'(seg), 'h66);
    end

    // Freeze with button activity
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btn = (i < 7) ? logic'(i % 2) : 1'b0;
      step();
    end
    check("frz_page", int'(pg), 3);
    check("frz_seg", int'(seg), 'h66);
    ena = 1'b1;
    auto_m = 1'b1;
    repeat (8) step();
    check("resume", int'(pg), 4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        idx = int'($urandom_range(1, 6));
        stv[idx] = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 15) == 0) status = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) btn = ~btn;
      if ($urandom_range(0, 29) == 0) auto_m = ~auto_m;
      ena = ($urandom_range(0, 9) != 0);
      if (i == 200) reset_mid();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
